// File: rtl/tdc_pkg.sv
// Shared TDC definitions: default geometry, clog2 helper, edge encoding and
// the record field positions that readout software/RTL decodes.
//
// Record layout (LSB first): fine | coarse | [edge] | ch
//   edge bit exists only when TDC_FALLING_EDGE_EN is defined.
//
// Build macro: TDC_FALLING_EDGE_EN -- also timestamp falling tap0 edges.
package tdc_pkg;

  localparam int unsigned TDC_NUM_TAPS = 120;
  localparam int unsigned TDC_FINE_W   = 7;
  localparam int unsigned TDC_COARSE_W = 10;

`ifdef TDC_FALLING_EDGE_EN
  localparam int unsigned EDGE_W = 1;
`else
  localparam int unsigned EDGE_W = 0;
`endif

  typedef enum logic {
    EdgeRise = 1'b0,
    EdgeFall = 1'b1
  } tdc_edge_e;

  // Field positions for the default geometry.
  localparam int unsigned FINE_LSB   = 0;
  localparam int unsigned COARSE_LSB = FINE_LSB + TDC_FINE_W;
  localparam int unsigned EDGE_BIT   = COARSE_LSB + TDC_COARSE_W;  // valid only with edge bit
  localparam int unsigned CH_LSB     = EDGE_BIT + EDGE_W;

  function automatic int unsigned tdc_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdc_fine_encoder.sv
// Two-stage pipelined popcount of one channel's thermometer snapshot.
// Stage A (registered): partial counts over 32-tap groups.
// Stage B (combinational from stage A): group sum, saturated to FINE_W bits;
// the consumer registers it.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   valid_i, taps_i   snapshot to count (already registered upstream)
//   meta_i            side data travelling alongside the count
//   valid_o, fine_o   count one cycle after valid_i
//   meta_o            side data aligned with fine_o
module tdc_fine_encoder
  import tdc_pkg::*;
#(
  parameter int unsigned NUM_TAPS = TDC_NUM_TAPS,
  parameter int unsigned FINE_W   = TDC_FINE_W,
  parameter int unsigned META_W   = TDC_COARSE_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [NUM_TAPS-1:0] taps_i,
  input  logic [META_W-1:0]   meta_i,
  output logic                valid_o,
  output logic [FINE_W-1:0]   fine_o,
  output logic [META_W-1:0]   meta_o
);

  localparam int unsigned GrpW    = 32;
  localparam int unsigned NumGrp  = (NUM_TAPS + GrpW - 1) / GrpW;
  localparam int unsigned PadW    = NumGrp * GrpW;
  localparam int unsigned PartW   = 6;
  localparam int unsigned SumW    = tdc_clog2(NUM_TAPS + 1);
  localparam int unsigned FineMax = (1 << FINE_W) - 1;

  logic [PadW-1:0]              taps_pad;
  logic [NumGrp-1:0][PartW-1:0] part_d, part_q;
  logic [META_W-1:0]            meta_q;
  logic                         vld_q;
  logic [SumW-1:0]              sum;

  assign taps_pad = PadW'(taps_i);

  always_comb begin
    part_d = '0;
    for (int unsigned g = 0; g < NumGrp; g++) begin
      for (int unsigned b = 0; b < GrpW; b++) begin
        part_d[g] = part_d[g] + PartW'(taps_pad[g*GrpW + b]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) vld_q <= 1'b0;
    else       vld_q <= valid_i;
  end

  always_ff @(posedge clk_i) begin
    part_q <= part_d;
    meta_q <= meta_i;
  end

  always_comb begin
    sum = '0;
    for (int unsigned g = 0; g < NumGrp; g++) sum = sum + SumW'(part_q[g]);
    if (32'(sum) > FineMax) fine_o = '1;
    else                    fine_o = FINE_W'(sum);
  end

  assign valid_o = vld_q;
  assign meta_o  = meta_q;

endmodule

// File: rtl/tdc_multichannel.sv
// Multi-channel TDC back end. Per channel: tap0 edge detect, snapshot
// register (S1), pipelined popcount (S2), 1-entry holding register (S3).
// A round-robin arbiter moves one held record per cycle into a
// first-word-fall-through output FIFO.
//
// Ports:
//   iClk, iRst  clock, synchronous active-high reset
//   iTaps       per-channel thermometer snapshots, channel c at [c*NUM_TAPS +: NUM_TAPS]
//   oTDC        record {ch, [edge], coarse, fine} at FIFO head, 0 when empty
//   oValid      oTDC valid; popped on oValid & iReady
//   iReady      consumer ready
//   oLost       sticky per-channel record-dropped flags
//   oCoarse     live coarse counter
//
// Build macro: TDC_FALLING_EDGE_EN -- falling edges also timestamped
// (fine = count of zeros), edge bit inserted between ch and coarse.
module tdc_multichannel
  import tdc_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned NUM_TAPS   = TDC_NUM_TAPS,
  parameter int unsigned FINE_W     = TDC_FINE_W,
  parameter int unsigned COARSE_W   = TDC_COARSE_W,
  parameter int unsigned FIFO_DEPTH = 16,
  // Single-channel builds still carry a 1-bit ch field.
  localparam int unsigned CH_W      = (NUM_CH > 1) ? tdc_clog2(NUM_CH) : 1,
  localparam int unsigned DIG_OUT   = CH_W + EDGE_W + COARSE_W + FINE_W
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic [NUM_CH*NUM_TAPS-1:0]   iTaps,
  output logic [DIG_OUT-1:0]           oTDC,
  output logic                         oValid,
  input  logic                         iReady,
  output logic [NUM_CH-1:0]            oLost,
  output logic [COARSE_W-1:0]          oCoarse
);

  localparam int unsigned META_W = EDGE_W + COARSE_W;
  localparam int unsigned AW     = tdc_clog2(FIFO_DEPTH);

  // Coarse counter
  logic [COARSE_W-1:0] coarse_d, coarse_q;
  assign coarse_d = coarse_q + COARSE_W'(1);

  // Edge detect and S1
  logic [NUM_CH-1:0]                tap0_q;
  logic [NUM_CH-1:0]                ev;
  logic [NUM_CH-1:0]                s1_vld_q;
  logic [NUM_CH-1:0][NUM_TAPS-1:0]  s1_taps_d, s1_taps_q;
  logic [NUM_CH-1:0][META_W-1:0]    s1_meta_d, s1_meta_q;

  always_comb begin
    ev        = '0;
    s1_taps_d = '0;
    s1_meta_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      s1_taps_d[c] = iTaps[c*NUM_TAPS +: NUM_TAPS];
`ifdef TDC_FALLING_EDGE_EN
      // Opposite-polarity transitions only, so each edge re-arms the other.
      ev[c] = iTaps[c*NUM_TAPS] ^ tap0_q[c];
      if (!iTaps[c*NUM_TAPS]) begin
        s1_taps_d[c] = ~iTaps[c*NUM_TAPS +: NUM_TAPS];  // count zeros
        s1_meta_d[c] = {EdgeFall, coarse_q};
      end else begin
        s1_meta_d[c] = {EdgeRise, coarse_q};
      end
`else
      ev[c]        = iTaps[c*NUM_TAPS] & ~tap0_q[c];
      s1_meta_d[c] = coarse_q;
`endif
    end
  end

  // S2: per-channel popcount
  logic [NUM_CH-1:0]              enc_vld;
  logic [NUM_CH-1:0][FINE_W-1:0]  enc_fine;
  logic [NUM_CH-1:0][META_W-1:0]  enc_meta;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tdc_fine_encoder #(
      .NUM_TAPS (NUM_TAPS),
      .FINE_W   (FINE_W),
      .META_W   (META_W)
    ) u_enc (
      .clk_i   (iClk),
      .rst_i   (iRst),
      .valid_i (s1_vld_q[c]),
      .taps_i  (s1_taps_q[c]),
      .meta_i  (s1_meta_q[c]),
      .valid_o (enc_vld[c]),
      .fine_o  (enc_fine[c]),
      .meta_o  (enc_meta[c])
    );
  end

  // FIFO status
  logic [AW:0]        wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [DIG_OUT-1:0] mem_q [FIFO_DEPTH];
  logic               fifo_empty, fifo_full, fifo_pop, fifo_wr, can_wr;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_pop   = !fifo_empty && iReady;
  // A pop this cycle frees the slot the grant writes into.
  assign can_wr     = !fifo_full || fifo_pop;

  // Round-robin arbiter
  logic [NUM_CH-1:0]   hold_vld_d, hold_vld_q;
  logic [DIG_OUT-1:0]  hold_rec_d [NUM_CH];
  logic [DIG_OUT-1:0]  hold_rec_q [NUM_CH];
  logic [NUM_CH-1:0]   gnt;
  logic [CH_W-1:0]     ptr_d, ptr_q;
  logic [DIG_OUT-1:0]  gnt_rec;

  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_rec = '0;
    ptr_d   = ptr_q;
    fifo_wr = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!fifo_wr && can_wr && hold_vld_q[idx]) begin
        fifo_wr  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_rec  = hold_rec_q[idx];
        ptr_d    = (idx + 1 >= NUM_CH) ? '0 : CH_W'(idx + 1);
      end
    end
  end

  // S3 holding registers; a slot granted this cycle may reload immediately.
  logic [NUM_CH-1:0] lost_d, lost_q;

  always_comb begin
    hold_vld_d = hold_vld_q;
    lost_d     = lost_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      hold_rec_d[c] = hold_rec_q[c];
      if (gnt[c]) hold_vld_d[c] = 1'b0;
      if (enc_vld[c]) begin
        if (hold_vld_d[c]) begin
          lost_d[c] = 1'b1;
        end else begin
          hold_vld_d[c] = 1'b1;
          hold_rec_d[c] = {CH_W'(c), enc_meta[c], enc_fine[c]};
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_wr)  wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (fifo_pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      coarse_q   <= '0;
      tap0_q     <= '1;
      s1_vld_q   <= '0;
      hold_vld_q <= '0;
      lost_q     <= '0;
      ptr_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      coarse_q   <= coarse_d;
      for (int unsigned c = 0; c < NUM_CH; c++) tap0_q[c] <= iTaps[c*NUM_TAPS];
      s1_vld_q   <= ev;
      hold_vld_q <= hold_vld_d;
      lost_q     <= lost_d;
      ptr_q      <= ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Data paths qualified by the valid flags above need no reset.
  always_ff @(posedge iClk) begin
    s1_taps_q  <= s1_taps_d;
    s1_meta_q  <= s1_meta_d;
    hold_rec_q <= hold_rec_d;
    if (fifo_wr) mem_q[wr_ptr_q[AW-1:0]] <= gnt_rec;
  end

  assign oValid  = !fifo_empty;
  assign oTDC    = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign oLost   = lost_q;
  assign oCoarse = coarse_q;

endmodule
